// File: rtl/ub_read_streamer.sv
// -----------------------------------------------------------------------------
// ub_read_streamer
//
// Read-side initiator for the single-port unified buffer. A start command
// latches a base address and a word count, the block issues sequential reads
// to the buffer and forwards the returned words, in order, on a valid/ready
// stream toward the array feeder. A 2-entry skid FIFO absorbs the buffer's
// one-cycle registered read latency so backpressure never drops or repeats a
// word.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   start            command strobe, only honoured in IDLE
//   base_addr        first word address, captured with start
//   length           word count, captured with start (clamped to 2^ADDRESSSIZE)
//   busy             high while a non-empty command is being executed
//   done             one-cycle completion pulse
//   ub_write_enable  buffer write enable, constant 0
//   ub_address       registered buffer address
//   ub_data_out      buffer read data (valid the cycle after an address is read)
//   m_valid          stream word valid
//   m_ready          downstream ready
//   m_data           stream word
//   m_last           marks the final word of a command
//
// Stream handshake: a beat transfers on a rising clk edge where m_valid and
// m_ready are both high. Once m_valid is raised, it and m_data/m_last stay
// unchanged until that transfer happens; m_valid never depends on m_ready.
// -----------------------------------------------------------------------------
module ub_read_streamer #(
    parameter int ADDRESSSIZE = 10,
    parameter int WORDSIZE    = 64,
    parameter int LENSIZE     = ADDRESSSIZE + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDRESSSIZE-1:0] base_addr,
    input  logic [LENSIZE-1:0]     length,
    output logic                   busy,
    output logic                   done,
    output logic                   ub_write_enable,
    output logic [ADDRESSSIZE-1:0] ub_address,
    input  logic [WORDSIZE-1:0]    ub_data_out,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WORDSIZE-1:0]    m_data,
    output logic                   m_last
);

    // Largest word count a single command may request: the whole buffer.
    localparam logic [LENSIZE-1:0] MAX_LEN = LENSIZE'(1) << ADDRESSSIZE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Command registers
    logic [LENSIZE-1:0] len_q;      // clamped word count of the running command
    logic [LENSIZE-1:0] issued;     // reads issued so far

    // Read pipeline: the buffer samples ub_address at the issuing edge and its
    // data is pushed into the FIFO at the following edge.
    logic inflight;
    logic inflight_last;

    // 2-entry skid FIFO
    logic [WORDSIZE-1:0] fifo_data [2];
    logic [1:0]          fifo_last;
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_count;

    logic               push;
    logic               pop;
    logic               start_go;
    logic               issue;
    logic [2:0]         occupancy;
    logic [LENSIZE-1:0] length_clamped;

    assign ub_write_enable = 1'b0;

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = fifo_data[rd_ptr];
    assign m_last  = fifo_last[rd_ptr];

    assign pop  = m_valid & m_ready;
    assign push = inflight;

    assign start_go       = (state == S_IDLE) && start;
    assign length_clamped = (length > MAX_LEN) ? MAX_LEN : length;

    // Words that will occupy the FIFO once everything already in flight has
    // landed, after this cycle's pop. Issuing only while this is below 2
    // guarantees the new word has a slot even if the consumer stalls from now
    // on, while still allowing one issue per cycle when a pop happens every
    // cycle.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

    assign issue = (state == S_READ) && (issued < len_q) && (occupancy < 3'd2);

    assign busy = (state == S_READ) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    // A zero-length command completes without touching the buffer.
                    state_next = (length != '0) ? S_READ : S_DONE;
                end
            end
            S_READ: begin
                if (issued == len_q) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The final beat is leaving now and nothing else is pending.
                if (pop && m_last && (fifo_count == 2'd1) && !inflight) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Command, address and read pipeline registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q         <= '0;
            issued        <= '0;
            ub_address    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            if (start_go && (length != '0)) begin
                // Present the first address now; it is read at the next edge.
                ub_address <= base_addr;
                len_q      <= length_clamped;
                issued     <= '0;
            end

            if (issue) begin
                issued <= issued + LENSIZE'(1);
                // Advance only when another word remains, so the address
                // rests on the final word once the command is fully issued.
                if ((issued + LENSIZE'(1)) < len_q) begin
                    ub_address <= ub_address + ADDRESSSIZE'(1);
                end
            end

            inflight      <= issue;
            inflight_last <= issue && (issued == (len_q - LENSIZE'(1)));
        end
    end

    // -------------------------------------------------------------------------
    // Skid FIFO
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            fifo_count   <= '0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= ub_data_out;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ub_read_streamer.sv
// -----------------------------------------------------------------------------
// tb_ub_read_streamer
//
// Drives ub_read_streamer against a behavioural unified buffer (registered
// read of a random-filled array). Each accepted command is expanded into the
// list of words it must deliver, straight from the addressing and length
// rules, and the stream is compared beat by beat against that list. done and
// busy timing are predicted from the beat that carries m_last.
// -----------------------------------------------------------------------------
module tb_ub_read_streamer;

    localparam int AW    = 10;
    localparam int DW    = 64;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] length = '0;
    logic          busy;
    logic          done;
    logic          ub_write_enable;
    logic [AW-1:0] ub_address;
    logic [DW-1:0] ub_data_out;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;

    ub_read_streamer #(
        .ADDRESSSIZE(AW),
        .WORDSIZE   (DW),
        .LENSIZE    (LW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .busy           (busy),
        .done           (done),
        .ub_write_enable(ub_write_enable),
        .ub_address     (ub_address),
        .ub_data_out    (ub_data_out),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last)
    );

    // Unified buffer: one-cycle registered read, no enable.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) ub_data_out <= mem[ub_address];

    // ---------------------------------------------------------------- scoreboard
    logic [DW:0]   exp_q [$];          // {last, data}
    logic [AW-1:0] addr_log [$];
    logic [AW-1:0] last_addr;

    int  vectors = 0;
    int  errors  = 0;
    int  cyc     = 0;
    int  done_at = -1;
    int  beats   = 0;
    int  ready_mode  = 0;
    int  ready_phase = 0;
    bit  model_active = 1'b0;
    bit  model_busy   = 1'b0;
    bit  prev_stall   = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- driver
    // Called at a falling edge: picks m_ready for the coming rising edge,
    // checks the outputs against the model, updates the model, then advances
    // one clock.
    task automatic step();
        logic [DW:0]   e;
        logic [AW-1:0] a;
        int            n;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = (ready_phase % 3 == 0);
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
        ready_phase++;

        if (prev_stall) begin
            check("stall_valid", DW'(m_valid), DW'(1));
            check("stall_data", m_data, prev_data);
            check("stall_last", DW'(m_last), DW'(prev_last));
        end
        check("done", DW'(done), DW'(cyc == done_at));
        check("busy", DW'(busy), DW'(model_busy && (cyc != done_at)));

        if (ub_address != last_addr) begin
            addr_log.push_back(ub_address);
            last_addr = ub_address;
        end

        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", DW'(m_valid), DW'(0));
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_data, e[DW-1:0]);
                check("beat_last", DW'(m_last), DW'(e[DW]));
                beats++;
                if (e[DW]) done_at = cyc + 1;
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;

        if (start && !model_active) begin
            model_active = 1'b1;
            n = (int'(length) > DEPTH) ? DEPTH : int'(length);
            if (n == 0) begin
                done_at = cyc + 1;
            end else begin
                model_busy = 1'b1;
                for (int i = 0; i < n; i++) begin
                    a = base_addr + AW'(i);
                    exp_q.push_back({(i == n - 1), mem[a]});
                end
            end
        end
        if (cyc == done_at) begin
            model_active = 1'b0;
            model_busy   = 1'b0;
        end

        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000 && model_active; k++) step();
        check("timeout", DW'(model_active), DW'(0));
        step();
        step();
    endtask

    task automatic run_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l, input int mode);
        ready_mode = mode;
        base_addr  = b;
        length     = l;
        start      = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        int            b0;
        logic [AW-1:0] a0;

        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom(), $urandom()};
        for (int i = 0; i < 4; i++) mem[8 + i] = DW'(8'hA0 + i);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_done", DW'(done), DW'(0));
        check("rst_we", DW'(ub_write_enable), DW'(0));
        check("rst_addr", DW'(ub_address), DW'(0));
        check("rst_valid", DW'(m_valid), DW'(0));
        check("rst_data", m_data, DW'(0));
        check("rst_last", DW'(m_last), DW'(0));
        rst_n = 1'b1;
        last_addr = ub_address;
        step();

        // Basic stream with first-beat latency
        b0 = beats;
        ready_mode = 0;
        base_addr = AW'(8);
        length = LW'(4);
        start = 1'b1;
        step();
        start = 1'b0;
        check("lat_addr", DW'(ub_address), DW'(8));
        check("lat_valid_1", DW'(m_valid), DW'(0));
        step();
        check("lat_valid_2", DW'(m_valid), DW'(0));
        step();
        check("lat_valid_3", DW'(m_valid), DW'(1));
        check("lat_first_data", m_data, DW'(8'hA0));
        wait_idle();
        check("basic_beats", DW'(beats - b0), DW'(4));

        // Backpressure 1,0,0 pattern
        b0 = beats;
        run_cmd(AW'(0), LW'(8), 1);
        check("bp_beats", DW'(beats - b0), DW'(8));

        // Address wrap
        addr_log.delete();
        last_addr = ub_address;
        b0 = beats;
        run_cmd(AW'(1022), LW'(4), 2);
        check("wrap_beats", DW'(beats - b0), DW'(4));
        check("wrap_addr_n", DW'(addr_log.size()), DW'(4));
        if (addr_log.size() == 4) begin
            check("wrap_addr_0", DW'(addr_log[0]), DW'(1022));
            check("wrap_addr_1", DW'(addr_log[1]), DW'(1023));
            check("wrap_addr_2", DW'(addr_log[2]), DW'(0));
            check("wrap_addr_3", DW'(addr_log[3]), DW'(1));
        end

        // Zero length
        a0 = ub_address;
        b0 = beats;
        run_cmd(AW'(500), LW'(0), 0);
        check("zero_addr", DW'(ub_address), DW'(a0));
        check("zero_beats", DW'(beats - b0), DW'(0));

        // Clamp
        b0 = beats;
        run_cmd(AW'(37), LW'(2047), 0);
        check("clamp_beats", DW'(beats - b0), DW'(1024));

        // start while busy is ignored
        b0 = beats;
        ready_mode = 0;
        base_addr = AW'(100);
        length = LW'(4);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        base_addr = AW'(200);
        length = LW'(9);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        check("busy_start_beats", DW'(beats - b0), DW'(4));

        // Reset in the middle of a transfer
        b0 = beats;
        ready_mode = 0;
        base_addr = AW'(300);
        length = LW'(6);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20 && (beats - b0) < 2; k++) step();
        check("mid_beats", DW'(beats - b0), DW'(2));
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", DW'(busy), DW'(0));
        check("mid_rst_done", DW'(done), DW'(0));
        check("mid_rst_addr", DW'(ub_address), DW'(0));
        check("mid_rst_valid", DW'(m_valid), DW'(0));
        check("mid_rst_data", m_data, DW'(0));
        check("mid_rst_last", DW'(m_last), DW'(0));
        exp_q.delete();
        model_active = 1'b0;
        model_busy   = 1'b0;
        done_at      = -1;
        prev_stall   = 1'b0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        last_addr = ub_address;
        for (int k = 0; k < 5; k++) begin
            check("post_rst_valid", DW'(m_valid), DW'(0));
            step();
        end

        // Randomized commands
        for (int t = 0; t < 20; t++) begin
            b0 = beats;
            run_cmd(AW'($urandom_range(0, DEPTH - 1)), LW'($urandom_range(1, 24)), 2);
            check("rand_drained", DW'(exp_q.size()), DW'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ub_read_streamer.md
Name: ub_read_streamer

Overview:
- Read-side initiator for the single-port unified buffer: 64-bit words, 1-cycle registered read latency, no handshake on the buffer side.
- On a start command, issues sequential reads from a base address for a given word count.
- Delivers the returned words in order on a valid/ready stream toward the array feeder.
- Absorbs the buffer's fixed read latency under backpressure with a 2-entry skid FIFO, so no word is lost or duplicated.

Parameters:
ADDRESSSIZE, 10, unified buffer address width
WORDSIZE, 64, unified buffer word width (8 bytes)
LENSIZE, ADDRESSSIZE+1, width of the length field (max count = 2^ADDRESSSIZE)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe, sampled in IDLE only
base_addr  input  ADDRESSSIZE  first word address, sampled with start
length  input  LENSIZE  word count, sampled with start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  single-cycle completion pulse
ub_write_enable  output  1  buffer write enable, tied 0 (read-only master)
ub_address  output  ADDRESSSIZE  buffer address, registered
ub_data_out  input  WORDSIZE  buffer read data, valid the cycle after its address is captured
m_valid  output  1  stream word valid
m_ready  input  1  downstream ready
m_data  output  WORDSIZE  stream word
m_last  output  1  high on the final word of a command

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, in-flight flag cleared, counters 0.
- Reset output values: busy=0, done=0, ub_address=0, m_valid=0, m_data=0, m_last=0, ub_write_enable=0.
- Mid-operation reset: any in-flight read data is discarded; no partial beats after release.
- States:
  - IDLE -> READ on start with length!=0.
  - IDLE -> DONE on start with length==0. No reads; done pulses the next cycle; busy stays 0.
  - READ -> DRAIN when the issued count reaches the latched length.
  - DRAIN -> DONE when the FIFO is empty, nothing is in flight, and the last beat has been accepted.
  - DONE -> IDLE unconditionally. done=1 for exactly that cycle; busy drops the same cycle.
- Length clamp: lengths above 2^ADDRESSSIZE are clamped to 2^ADDRESSSIZE.
- start outside IDLE is ignored. No queuing, no effect on the running transfer.
- Issue rule: a read is issued in a cycle (ub_address <= next address, in-flight flag set for the following cycle) iff state is READ, issued < length, and fifo_count + inflight - pop < 2, where pop = m_valid & m_ready.
  - Sustains 1 word/cycle with m_ready held high.
  - Never overflows the 2-entry FIFO.
- Addressing: word i of a command reads address (base_addr + i) mod 2^ADDRESSSIZE; wraps 1023 -> 0 at the default parameters.
- Read return: when the in-flight flag is set, ub_data_out is pushed into the FIFO at the next edge. When the flag is clear, ub_data_out is ignored.
- Latency: start sampled at edge E0 -> ub_address=base after E0 -> buffer reads at E1 -> push at E2 -> m_valid=1 after E2. First beat appears 2 cycles after the start cycle.
- Stream rules:
  - m_valid = FIFO non-empty.
  - m_data and m_last hold stable while m_valid && !m_ready.
  - A beat transfers on m_valid && m_ready.
  - m_last is tagged on the word whose index equals length-1.
- Simultaneous push and pop keeps the FIFO count unchanged; ordering is strictly FIFO.
- ub_address holds its last value when not issuing.

Test Plan:
- Basic stream: base=8, length=4, mem[8..11]=A0..A3, m_ready=1 -> m_valid on 4 consecutive cycles starting 2 cycles after start; data A0,A1,A2,A3; m_last only on A3; done pulses 1 cycle after the A3 handshake; busy low the same cycle.
- Backpressure: base=0, length=8, m_ready toggling 1,0,0,1,... -> all 8 words delivered exactly once, in order; m_data stable during stalls; ub_address never advances while the FIFO is full with a read in flight.
- Wrap: base=1022, length=4 -> ub_address sequence 1022,1023,0,1; data mem[1022],mem[1023],mem[0],mem[1].
- Zero length and clamp:
  - length=0 -> no address change, no m_valid, done pulses the cycle after start, busy stays 0.
  - length=2047 -> exactly 1024 beats.
- start while busy: second start with a different base/length mid-transfer -> ignored; the original 4-beat sequence completes unchanged.
- Reset mid-op: rst_n low for 1 cycle after 2 of 6 beats -> all outputs at reset values immediately; after release, no m_valid until a new start.
